// File: rtl/expr_sched_pkg.sv
// Shared types and constants for the expression-evaluator scheduler.
package expr_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CLEAR,
        ST_STREAM,
        ST_SAMPLE,
        ST_RESP
    } state_t;

    localparam logic [7:0] CH_TERM = 8'h3D;
    localparam logic [7:0] CH_NUL  = 8'h00;

    // Width able to hold a length count from 0 up to max_len inclusive.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/expr_eval_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   gid
);

    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_idx;
    logic           w_found;

    always_comb begin
        grant   = '0;
        gid     = '0;
        w_sum   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            // Extra bit so the wrap works for non-power-of-two N_REQ.
            w_sum = {1'b0, ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(N_REQ)) begin
                w_sum = w_sum - (IDW+1)'(N_REQ);
            end
            w_idx = w_sum[IDW-1:0];
            if (!w_found && req[w_idx]) begin
                w_found      = 1'b1;
                grant[w_idx] = 1'b1;
                gid          = w_idx;
            end
        end
    end

endmodule

// File: rtl/expr_eval_sched.sv
// Shares one character-stream evaluator among N_REQ requesters: buffer an
// expression, replay it gap-free into the evaluator, return a tagged response.
//
// state   | meaning
// IDLE    | waiting for any requester; grants round-robin
// COLLECT | accepting bytes from the granted requester until '='
// CLEAR   | one cycle of ev_clr before the replay
// STREAM  | replaying buffered bytes on consecutive cycles
// SAMPLE  | evaluator flags settled; capture judge/result
// RESP    | response held until rsp_ready
module expr_eval_sched
    import expr_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MAX_LEN = 16,
    parameter int IDW     = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic               rsp_ok,
    output logic [31:0]        rsp_result,
    output logic [7:0]         ev_in,
    output logic               ev_clr,
    input  logic               ev_judge,
    input  logic [31:0]        ev_result
);

    localparam int LW = len_width(MAX_LEN);
    localparam int AW = $clog2(MAX_LEN);

    state_t         r_state;
    logic [IDW-1:0] r_gid;
    logic [IDW-1:0] r_ptr;
    logic [LW-1:0]  r_len;
    logic [LW-1:0]  r_idx;
    logic           r_ovf;
    logic [7:0]     r_buf [MAX_LEN];

    logic [N_REQ-1:0] w_grant;
    logic [IDW-1:0]   w_gid;
    logic [7:0]       w_byte;
    logic             w_fire;
    logic             w_term;
    logic             w_full;
    logic             w_buf_we;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (r_ptr),
        .grant (w_grant),
        .gid   (w_gid)
    );

    assign w_byte   = req_data[{r_gid, 3'b000} +: 8];
    assign w_fire   = (r_state == ST_COLLECT) && req_valid[r_gid];
    assign w_term   = (w_byte == CH_TERM);
    assign w_full   = (r_len == LW'(MAX_LEN));
    assign w_buf_we = w_fire && !w_term && !w_full;

    always_comb begin
        req_ready = '0;
        if (r_state == ST_COLLECT) begin
            req_ready[r_gid] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buf[r_len[AW-1:0]] <= w_byte;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state    <= ST_IDLE;
            r_gid      <= '0;
            r_ptr      <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_ovf      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_ok     <= 1'b0;
            rsp_result <= '0;
            ev_in      <= CH_NUL;
            ev_clr     <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_grant) begin
                        r_gid   <= w_gid;
                        r_ptr   <= (w_gid == IDW'(N_REQ-1)) ? '0 : w_gid + 1'b1;
                        r_len   <= '0;
                        r_ovf   <= 1'b0;
                        r_state <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (w_fire) begin
                        if (w_term) begin
                            if (r_len == '0 || r_ovf) begin
                                r_state    <= ST_RESP;
                                rsp_valid  <= 1'b1;
                                rsp_id     <= r_gid;
                                rsp_ok     <= 1'b0;
                                rsp_result <= '0;
                            end else begin
                                r_state <= ST_CLEAR;
                            end
                        end else if (w_full) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_len <= r_len + 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    // ev_in is registered, so the first byte is issued here.
                    ev_clr  <= 1'b0;
                    ev_in   <= r_buf[0];
                    r_idx   <= LW'(1);
                    r_state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (r_idx == r_len) begin
                        ev_in   <= CH_NUL;
                        r_state <= ST_SAMPLE;
                    end else begin
                        ev_in <= r_buf[r_idx[AW-1:0]];
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    ev_clr     <= 1'b1;
                    rsp_valid  <= 1'b1;
                    rsp_id     <= r_gid;
                    rsp_ok     <= ev_judge;
                    rsp_result <= ev_judge ? ev_result : 32'd0;
                    r_state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_expr_eval_sched.sv
// Scoreboard bench for expr_eval_sched with a behavioural evaluator stand-in.
module tb_expr_eval_sched;

    localparam int N  = 4;
    localparam int ML = 16;

    typedef struct packed {
        logic        ok;
        logic [31:0] res;
    } exp_t;

    logic           clk = 1'b0;
    logic           clr = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [1:0]     rsp_id;
    logic           rsp_ok;
    logic [31:0]    rsp_result;
    logic [7:0]     ev_in;
    logic           ev_clr;
    logic           ev_judge = 1'b0;
    logic [31:0]    ev_result = '0;

    expr_eval_sched #(.N_REQ(N), .MAX_LEN(ML)) dut (
        .clk        (clk),
        .clr        (clr),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_ok     (rsp_ok),
        .rsp_result (rsp_result),
        .ev_in      (ev_in),
        .ev_clr     (ev_clr),
        .ev_judge   (ev_judge),
        .ev_result  (ev_result)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Character-serial evaluator stand-in: judge/result registered.
    logic [31:0] e_sum, e_prod, e_cur;
    int          e_nd;
    bit          e_lz, e_err;

    always @(posedge clk) begin
        if (ev_clr) begin
            e_sum = 0; e_prod = 1; e_cur = 0; e_nd = 0; e_lz = 0; e_err = 0;
        end else if (ev_in >= 8'h30 && ev_in <= 8'h39) begin
            if (e_nd == 1 && e_lz) e_err = 1;
            e_lz  = (e_nd == 0) && (ev_in == 8'h30);
            e_cur = e_cur * 10 + 32'(ev_in - 8'h30);
            e_nd++;
        end else if (ev_in == 8'h2B || ev_in == 8'h2A) begin
            if (e_nd == 0) e_err = 1;
            if (ev_in == 8'h2B) begin
                e_sum  = e_sum + e_prod * e_cur;
                e_prod = 1;
            end else begin
                e_prod = e_prod * e_cur;
            end
            e_cur = 0;
            e_nd  = 0;
        end else begin
            e_err = 1;
        end
        ev_judge  <= !e_err && (e_nd > 0);
        ev_result <= e_sum + e_prod * e_cur;
    end

    // Reference: tokenise on operators, reject empty or leading-zero numbers.
    function automatic void ref_eval(input logic [7:0] e[$], output logic ok, output logic [31:0] res);
        logic [31:0] sum, prod, val;
        logic [7:0]  c, first;
        int          tlen;
        bit          bad;
        ok = 1'b0;
        res = '0;
        if (e.size() == 0 || e.size() > ML) return;
        sum = 0; prod = 1; val = 0; tlen = 0; bad = 0; first = 8'h00;
        for (int k = 0; k <= e.size(); k++) begin
            c = (k == e.size()) ? 8'h2B : e[k];
            if (c >= 8'h30 && c <= 8'h39) begin
                if (tlen == 0) first = c;
                val = val * 10 + 32'(c - 8'h30);
                tlen++;
            end else begin
                if (tlen == 0 || (tlen > 1 && first == 8'h30)) bad = 1;
                prod = prod * val;
                val  = 0;
                tlen = 0;
                if (c == 8'h2B) begin
                    sum  = sum + prod;
                    prod = 1;
                end
            end
        end
        if (!bad) begin
            ok  = 1'b1;
            res = sum;
        end
    endfunction

    logic [7:0] drv_q [N][$];
    exp_t       exp_q [N][$];
    int         id_log [$];

    task automatic send_bytes(input int id, input logic [7:0] e[$]);
        logic        ok;
        logic [31:0] res;
        ref_eval(e, ok, res);
        exp_q[id].push_back({ok, res});
        foreach (e[k]) drv_q[id].push_back(e[k]);
        drv_q[id].push_back(8'h3D);
    endtask

    task automatic send(input int id, input string s);
        logic [7:0] q[$];
        for (int k = 0; k < s.len(); k++) begin
            if (s[k] == 8'h3D) break;
            q.push_back(s[k]);
        end
        send_bytes(id, q);
    endtask

    function automatic int rr_pick(input int p, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    logic [N-1:0] fire_prev = '0;
    logic [N-1:0] last_valid = '0;
    logic [N-1:0] prev_rdy = '0;
    logic [N-1:0] drv_v;
    logic [N-1:0] g_exp;
    int           tb_ptr = 0;
    int           g_pick;
    bit           rnd_mode = 0;
    bit           hold_rsp = 0;
    bit           rsp_seen = 0;
    bit           lat_arm = 0;
    logic [34:0]  snap;
    int           lat_start = 0;
    int           last_lat = 0;
    int           n_ev_act = 0;
    int           n_fired = 0;
    exp_t         e_pop;

    // Requester drivers, grant model and response monitor share one process.
    always @(negedge clk) begin
        if (req_ready != '0 && prev_rdy == '0) begin
            g_pick = rr_pick(tb_ptr, last_valid);
            g_exp  = (g_pick < 0) ? '0 : N'(1) << g_pick;
            chk("grant", 64'(req_ready), 64'(g_exp));
            if (g_pick >= 0) tb_ptr = (g_pick + 1) % N;
        end
        prev_rdy = req_ready;

        for (int i = 0; i < N; i++) begin
            if (fire_prev[i] && drv_q[i].size() > 0) begin
                void'(drv_q[i].pop_front());
                n_fired++;
            end
        end
        for (int i = 0; i < N; i++) begin
            drv_v[i] = (drv_q[i].size() > 0) && (!rnd_mode || $urandom_range(0, 4) != 0);
            req_data[8*i +: 8] = drv_v[i] ? drv_q[i][0] : 8'h00;
        end
        req_valid  = drv_v;
        last_valid = drv_v;
        fire_prev  = drv_v & req_ready;

        if (!ev_clr) n_ev_act++;

        rsp_ready = hold_rsp ? 1'b0 : (rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1);

        if (rsp_valid) begin
            if (rsp_seen) begin
                chk("rsp_stable", 64'({rsp_id, rsp_ok, rsp_result}), 64'(snap));
            end else begin
                rsp_seen  = 1;
                snap      = {rsp_id, rsp_ok, rsp_result};
                last_lat  = cyc - lat_start;
            end
            if (rsp_ready) begin
                if (exp_q[rsp_id].size() == 0) begin
                    chk("rsp_unexpected", 64'(1), 64'(0));
                end else begin
                    e_pop = exp_q[rsp_id].pop_front();
                    chk("rsp_ok", 64'(rsp_ok), 64'(e_pop.ok));
                    chk("rsp_result", 64'(rsp_result), 64'(e_pop.res));
                end
                id_log.push_back(int'(rsp_id));
                rsp_seen = 0;
            end
        end

        if (lat_arm && |drv_v) begin
            lat_start = cyc;
            lat_arm   = 0;
        end
    end

    function automatic int pending();
        int p = 0;
        for (int i = 0; i < N; i++) p += drv_q[i].size() + exp_q[i].size();
        return p;
    endfunction

    task automatic wait_idle(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (pending() == 0 && !rsp_valid) break;
        end
        if (k >= budget) chk("wait_idle_timeout", 64'(pending()), 64'(0));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_rsp_id"}, 64'(rsp_id), 64'(0));
        chk({tag, "_rsp_ok"}, 64'(rsp_ok), 64'(0));
        chk({tag, "_rsp_result"}, 64'(rsp_result), 64'(0));
        chk({tag, "_ev_in"}, 64'(ev_in), 64'(0));
        chk({tag, "_ev_clr"}, 64'(ev_clr), 64'(1));
    endtask

    task automatic flush_model();
        for (int i = 0; i < N; i++) begin
            drv_q[i].delete();
            exp_q[i].delete();
        end
        fire_prev = '0;
        prev_rdy  = '0;
        tb_ptr    = 0;
        rsp_seen  = 0;
    endtask

    task automatic gen_expr(output logic [7:0] q[$]);
        int nt, nd, r;
        q.delete();
        if ($urandom_range(0, 9) < 7) begin
            nt = $urandom_range(1, 4);
            for (int t = 0; t < nt; t++) begin
                if (t > 0) q.push_back(($urandom_range(0, 1) != 0) ? 8'h2B : 8'h2A);
                nd = $urandom_range(1, 3);
                for (int d = 0; d < nd; d++) q.push_back(8'h30 + 8'($urandom_range(0, 9)));
            end
        end else begin
            nt = $urandom_range(0, 18);
            for (int t = 0; t < nt; t++) begin
                r = $urandom_range(0, 11);
                q.push_back((r < 10) ? 8'h30 + 8'(r) : ((r == 10) ? 8'h2B : 8'h2A));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] q[$];
        int         n0;
        int         k;

        #2 clr = 1'b1;
        #1 chk_reset("por");
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 clr = 1'b0;

        // Simultaneous requests after reset: lower index from ptr=0 wins.
        send(1, "5=");
        send(3, "2*3=");
        wait_idle(400);
        chk("order_n", 64'(id_log.size()), 64'(2));
        if (id_log.size() == 2) begin
            chk("order_0", 64'(id_log[0]), 64'(1));
            chk("order_1", 64'(id_log[1]), 64'(3));
        end
        id_log.delete();
        send(1, "5=");
        send(3, "2*3=");
        wait_idle(400);
        chk("reorder_n", 64'(id_log.size()), 64'(2));
        if (id_log.size() == 2) chk("reorder_0", 64'(id_log[0]), 64'(1));

        lat_arm = 1;
        send(0, "12+3*4=");
        wait_idle(400);
        chk("latency_L6", 64'(last_lat), 64'(16));

        send(2, "1++2=");
        send(3, "07*3=");
        wait_idle(400);

        n0 = n_ev_act;
        send(0, "=");
        wait_idle(400);
        chk("empty_no_stream", 64'(n_ev_act - n0), 64'(0));

        n0 = n_fired;
        q.delete();
        for (int i = 0; i < 20; i++) q.push_back(8'h31);
        send_bytes(0, q);
        wait_idle(400);
        chk("ovf_bytes_accepted", 64'(n_fired - n0), 64'(21));

        // Asynchronous reset in the middle of the replay.
        send(0, "9*9+1=");
        for (k = 0; k < 200 && ev_clr; k++) @(negedge clk);
        chk("reach_stream", 64'(ev_clr), 64'(0));
        #1 clr = 1'b1;
        #1 chk_reset("mid");
        flush_model();
        @(posedge clk);
        @(negedge clk);
        #1 clr = 1'b0;

        hold_rsp = 1;
        send(2, "3+4=");
        for (k = 0; k < 200 && !rsp_valid; k++) @(negedge clk);
        chk("hold_rsp_seen", 64'(rsp_valid), 64'(1));
        send(1, "9=");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("hold_valid", 64'(rsp_valid), 64'(1));
            chk("hold_req_ready", 64'(req_ready), 64'(0));
        end
        hold_rsp = 0;
        wait_idle(400);

        rnd_mode = 1;
        for (int t = 0; t < 40; t++) begin
            gen_expr(q);
            send_bytes($urandom_range(0, N-1), q);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        wait_idle(20000);
        rnd_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
